// File: rtl/key_event_decoder_if.sv
// Key-event bundle between one push-button front end and its consumers.
// The slave side is the decoder; the master side owns the raw key line.
interface key_event_decoder_if;
  logic btn_n_i;
  logic pressed_o;
  logic short_pulse_o;
  logic long_pulse_o;
  logic repeat_pulse_o;

  modport master (
    output btn_n_i,
    input  pressed_o,
    input  short_pulse_o,
    input  long_pulse_o,
    input  repeat_pulse_o
  );

  modport slave (
    input  btn_n_i,
    output pressed_o,
    output short_pulse_o,
    output long_pulse_o,
    output repeat_pulse_o
  );
endinterface

// File: rtl/key_event_decoder.sv
// Synchronises and debounces one active-low key, then classifies each press
// as short, long, or long with auto-repeat using single-cycle event pulses.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | key released and confirmed, waiting for a low sample
// DEB_PRESS   | key seen low, counting stable cycles before accepting it
// HELD        | press confirmed, hold timer running toward a long press
// LONG_HELD   | long press reported, repeat timer issuing auto-repeats
// DEB_RELEASE | key seen high, counting stable cycles before accepting it
module key_event_decoder #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned LONG_CYC     = 50_000_000,
  parameter int unsigned REPEAT_CYC   = 10_000_000
) (
  input logic                clk_i,
  input logic                rst_i,
  key_event_decoder_if.slave key_if
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);
  localparam int unsigned REP_W  = $clog2(REPEAT_CYC + 1);

  localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYC);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEB_PRESS,
    ST_HELD,
    ST_LONG_HELD,
    ST_DEB_RELEASE
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync2_q;
  logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
  logic                long_q, long_d;
  logic                pressed_q, pressed_d;
  logic                short_pulse_q, short_pulse_d;
  logic                long_pulse_q, long_pulse_d;
  logic                repeat_pulse_q, repeat_pulse_d;
  logic                key_up;

  assign key_up = sync2_q;

  always_comb begin
    state_d        = state_q;
    deb_cnt_d      = deb_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    rep_cnt_d      = rep_cnt_q;
    long_d         = long_q;
    pressed_d      = pressed_q;
    short_pulse_d  = 1'b0;
    long_pulse_d   = 1'b0;
    repeat_pulse_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!key_up) begin
          state_d   = ST_DEB_PRESS;
          deb_cnt_d = DEB_ONE;
        end
      end

      ST_DEB_PRESS: begin
        if (key_up) begin
          state_d = ST_IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = ST_HELD;
          pressed_d  = 1'b1;
          hold_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
      end

      // The cycle that sees the release still counts as a hold cycle, so the
      // long press slips only by the cycles actually spent in DEB_RELEASE.
      ST_HELD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          long_pulse_d = 1'b1;
          long_d       = 1'b1;
          state_d      = ST_LONG_HELD;
          rep_cnt_d    = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
          if (key_up) begin
            state_d   = ST_DEB_RELEASE;
            deb_cnt_d = DEB_ONE;
          end
        end
      end

      ST_LONG_HELD: begin
        if (rep_cnt_q == REP_LAST) begin
          repeat_pulse_d = 1'b1;
          rep_cnt_d      = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_ONE;
        end
        if (key_up) begin
          state_d   = ST_DEB_RELEASE;
          deb_cnt_d = DEB_ONE;
        end
      end

      ST_DEB_RELEASE: begin
        if (!key_up) begin
          state_d = long_q ? ST_LONG_HELD : ST_HELD;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d       = ST_IDLE;
          pressed_d     = 1'b0;
          short_pulse_d = !long_q;
          long_d        = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      state_q        <= ST_IDLE;
      deb_cnt_q      <= '0;
      hold_cnt_q     <= '0;
      rep_cnt_q      <= '0;
      long_q         <= 1'b0;
      pressed_q      <= 1'b0;
      short_pulse_q  <= 1'b0;
      long_pulse_q   <= 1'b0;
      repeat_pulse_q <= 1'b0;
    end else begin
      sync1_q        <= key_if.btn_n_i;
      sync2_q        <= sync1_q;
      state_q        <= state_d;
      deb_cnt_q      <= deb_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      rep_cnt_q      <= rep_cnt_d;
      long_q         <= long_d;
      pressed_q      <= pressed_d;
      short_pulse_q  <= short_pulse_d;
      long_pulse_q   <= long_pulse_d;
      repeat_pulse_q <= repeat_pulse_d;
    end
  end

  assign key_if.pressed_o      = pressed_q;
  assign key_if.short_pulse_o  = short_pulse_q;
  assign key_if.long_pulse_o   = long_pulse_q;
  assign key_if.repeat_pulse_o = repeat_pulse_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with short debounce/hold/repeat
// parameters; event cycles are logged and compared to hand-derived values.
module tb_key_event_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_event_decoder_if ifc ();

  key_event_decoder #(
    .DEBOUNCE_CYC (4),
    .LONG_CYC     (20),
    .REPEAT_CYC   (5)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .key_if (ifc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled half a cycle after each rising edge.
  int   rise_cyc = -1, fall_cyc = -1, short_cyc = -1, long_cyc = -1;
  int   n_rise = 0, n_fall = 0, n_short = 0, n_long = 0, n_rep = 0;
  int   width_err = 0, overlap_err = 0;
  int   rep_log [0:255];
  logic prev_pressed = 1'b0;
  logic [2:0] prev_pulse = 3'b000;
  logic [2:0] cur_pulse;

  assign cur_pulse = {ifc.short_pulse_o, ifc.long_pulse_o, ifc.repeat_pulse_o};

  always @(negedge clk) begin
    if (ifc.pressed_o && !prev_pressed) begin
      rise_cyc <= cyc;
      n_rise   <= n_rise + 1;
    end
    if (!ifc.pressed_o && prev_pressed) begin
      fall_cyc <= cyc;
      n_fall   <= n_fall + 1;
    end
    if (ifc.short_pulse_o) begin
      short_cyc <= cyc;
      n_short   <= n_short + 1;
    end
    if (ifc.long_pulse_o) begin
      long_cyc <= cyc;
      n_long   <= n_long + 1;
    end
    if (ifc.repeat_pulse_o) begin
      rep_log[n_rep[7:0]] <= cyc;
      n_rep               <= n_rep + 1;
    end
    if ((cur_pulse & prev_pulse) != 3'b000) width_err <= width_err + 1;
    if ($countones(cur_pulse) > 1) overlap_err <= overlap_err + 1;
    prev_pressed <= ifc.pressed_o;
    prev_pulse   <= cur_pulse;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int t0, t1;
  int b_rise, b_fall, b_short, b_long, b_rep;

  task automatic baseline();
    b_rise  = n_rise;
    b_fall  = n_fall;
    b_short = n_short;
    b_long  = n_long;
    b_rep   = n_rep;
  endtask

  initial begin
    ifc.btn_n_i = 1'b1;
    rst = 1'b1;
    step(3);
    chk("reset_outs", int'({ifc.pressed_o, ifc.short_pulse_o,
                            ifc.long_pulse_o, ifc.repeat_pulse_o}), 0);
    rst = 1'b0;
    step(5);

    // Clean short press
    baseline();
    t0 = cyc;
    ifc.btn_n_i = 1'b0;
    step(10);
    t1 = cyc;
    ifc.btn_n_i = 1'b1;
    step(12);
    chk("s1_rise_cyc",  rise_cyc, t0 + 7);
    chk("s1_fall_cyc",  fall_cyc, t1 + 7);
    chk("s1_short_cyc", short_cyc, t1 + 7);
    chk("s1_short_n",   n_short - b_short, 1);
    chk("s1_long_n",    n_long - b_long, 0);
    chk("s1_rep_n",     n_rep - b_rep, 0);

    // Bounce rejection: 2-cycle toggling, then low with 1-cycle high glitches
    baseline();
    for (int i = 0; i < 10; i++) begin
      ifc.btn_n_i = (i % 2 == 1);
      step(2);
    end
    ifc.btn_n_i = 1'b1;
    step(10);
    chk("s2_toggle_rise_n", n_rise - b_rise, 0);
    chk("s2_toggle_events", (n_short - b_short) + (n_long - b_long) + (n_rep - b_rep), 0);
    for (int i = 0; i < 24; i++) begin
      ifc.btn_n_i = (i % 3 == 2);
      step(1);
    end
    ifc.btn_n_i = 1'b1;
    step(10);
    chk("s2_glitch_rise_n", n_rise - b_rise, 0);
    chk("s2_glitch_pressed", int'(ifc.pressed_o), 0);
    chk("s2_glitch_events", (n_short - b_short) + (n_long - b_long) + (n_rep - b_rep), 0);

    // Long press with auto-repeat
    baseline();
    t0 = cyc;
    ifc.btn_n_i = 1'b0;
    step(45);
    t1 = cyc;
    ifc.btn_n_i = 1'b1;
    step(12);
    chk("s3_rise_cyc", rise_cyc, t0 + 7);
    chk("s3_long_cyc", long_cyc, t0 + 27);
    chk("s3_long_n",   n_long - b_long, 1);
    chk("s3_rep_n",    n_rep - b_rep, 4);
    chk("s3_rep0_cyc", rep_log[b_rep],     t0 + 32);
    chk("s3_rep1_cyc", rep_log[b_rep + 1], t0 + 37);
    chk("s3_rep2_cyc", rep_log[b_rep + 2], t0 + 42);
    chk("s3_fall_cyc", fall_cyc, t1 + 7);
    chk("s3_short_n",  n_short - b_short, 0);

    // Release bounce inside a hold delays the long press by 2 cycles
    baseline();
    t0 = cyc;
    ifc.btn_n_i = 1'b0;
    step(10);
    ifc.btn_n_i = 1'b1;
    step(2);
    ifc.btn_n_i = 1'b0;
    step(4);
    chk("s4_pressed_kept", int'(ifc.pressed_o), 1);
    chk("s4_no_fall",      n_fall - b_fall, 0);
    step(16);
    ifc.btn_n_i = 1'b1;
    step(12);
    chk("s4_rise_n",   n_rise - b_rise, 1);
    chk("s4_long_cyc", long_cyc, t0 + 29);
    chk("s4_rep_n",    n_rep - b_rep, 1);
    chk("s4_rep0_cyc", rep_log[b_rep], t0 + 34);
    chk("s4_fall_cyc", fall_cyc, t0 + 39);
    chk("s4_short_n",  n_short - b_short, 0);

    // Reset while held; the still-low key is re-detected from scratch
    baseline();
    t0 = cyc;
    ifc.btn_n_i = 1'b0;
    step(10);
    rst = 1'b1;
    step(1);
    chk("s5_reset_outs", int'({ifc.pressed_o, ifc.short_pulse_o,
                               ifc.long_pulse_o, ifc.repeat_pulse_o}), 0);
    rst = 1'b0;
    step(8);
    chk("s5_rerise_cyc", rise_cyc, t0 + 18);
    chk("s5_no_short",   n_short - b_short, 0);
    ifc.btn_n_i = 1'b1;
    step(12);
    chk("s5_short_cyc", short_cyc, t0 + 26);
    chk("s5_short_n",   n_short - b_short, 1);
    chk("s5_long_n",    n_long - b_long, 0);

    // Pulse shape over the whole run
    chk("pulse_width_errs",   width_err, 0);
    chk("pulse_overlap_errs", overlap_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Front-end stage for the mode and edit push-buttons. It synchronises one raw, active-low, bouncing key input and debounces it, then classifies each press as short, long, or long-with-auto-repeat. It emits single-cycle event pulses that the mode toggle and the character-edit controller consume directly. Each physical button gets one instance.

## Interface
Parameters:
- DEBOUNCE_CYC, default 1_000_000: consecutive stable cycles that confirm a press or release (20 ms at 50 MHz).
- LONG_CYC, default 50_000_000: confirmed-hold cycles before a long press (1 s).
- REPEAT_CYC, default 10_000_000: period of auto-repeat pulses after a long press (200 ms).

Ports:
- CLK  in  1  system clock, 50 MHz; every flop is on its rising edge.
- RST  in  1  reset, synchronous and active-high.
- BTN_N  in  1  raw key input, asynchronous, active-low (0 = pressed).
- PRESSED  out  1  debounced key level (1 = held).
- SHORT_PULSE  out  1  one-cycle pulse: a press was released before reaching LONG_CYC.
- LONG_PULSE  out  1  one-cycle pulse: the hold reached LONG_CYC.
- REPEAT_PULSE  out  1  one-cycle pulse every REPEAT_CYC cycles while the long hold continues.

## Operation
- **Synchroniser.** Two-flop synchroniser on BTN_N; both flops reset to 1. The FSM only sees the synchronised value `s`.
- **Counters.** Debounce counter, hold counter and repeat counter. Each is $clog2(parameter+1) bits wide. None of them ever wraps:
  - the hold counter stops counting once LONG_PULSE fires;
  - the repeat counter reloads to 0 when it fires.
- **FSM states:** IDLE, DEB_PRESS, HELD, LONG_HELD, DEB_RELEASE.
  - **IDLE** (PRESSED=0).
    - `s`=0 → DEB_PRESS, debounce counter = 1.
  - **DEB_PRESS.**
    - `s`=1 → IDLE. Bounce: no event, no PRESSED change.
    - `s`=0 and counter = DEBOUNCE_CYC → HELD; PRESSED=1; hold counter = 0. Otherwise the counter increments.
  - **HELD.**
    - Hold counter increments each cycle.
    - Counter reaches LONG_CYC-1 → LONG_PULSE=1 for that cycle; set the `long` flag; → LONG_HELD; repeat counter = 0.
    - `s`=1 → DEB_RELEASE, debounce counter = 1. The hold counter freezes.
  - **LONG_HELD.**
    - Repeat counter increments.
    - Counter reaches REPEAT_CYC-1 → REPEAT_PULSE=1, counter reloads to 0.
    - `s`=1 → DEB_RELEASE, debounce counter = 1. The repeat counter freezes.
  - **DEB_RELEASE** (PRESSED stays 1).
    - `s`=0 → back to HELD or LONG_HELD, chosen by the `long` flag. The frozen counters resume.
    - `s`=1 and counter = DEBOUNCE_CYC → IDLE; PRESSED=0; SHORT_PULSE=1 only if `long`=0; clear `long`.
- **Event ordering.** At most one event pulse fires in any cycle. A SHORT_PULSE never follows a LONG_PULSE for the same press.
- **Pulse outputs.** All three are registered and are never high for two consecutive cycles.

## Timing
- **Reset values.**
  - Outputs: PRESSED=0, SHORT_PULSE=0, LONG_PULSE=0, REPEAT_PULSE=0.
  - State IDLE; all counters 0; `long`=0; synchroniser flops 1.
- **Reset mid-operation.** The block returns to IDLE in the next cycle with no event emitted, including no SHORT_PULSE for a press that was in progress.
  - If BTN_N is still low after RST deasserts, the press is detected again from scratch. A full debounce is required.
- **Press latency.** PRESSED rises DEBOUNCE_CYC+2 cycles after the first edge that samples BTN_N low: 2 synchroniser cycles plus the debounce, provided BTN_N stays low.
- **Release latency.** PRESSED falls DEBOUNCE_CYC+2 cycles after the first edge that samples BTN_N high. SHORT_PULSE, when produced, is in the same cycle as the PRESSED fall.
- **Long press.** LONG_PULSE fires exactly LONG_CYC cycles after PRESSED rises, not counting cycles spent in DEB_RELEASE.
- **Repeat.** The first REPEAT_PULSE comes REPEAT_CYC cycles after LONG_PULSE, and then one every REPEAT_CYC cycles.
- **Glitches.** Any low or high glitch shorter than DEBOUNCE_CYC cycles changes nothing visible.

## Test plan
All scenarios use DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=5.

1. **Clean short press.** BTN_N low for 10 cycles, then high.
   - PRESSED rises 6 cycles after the low sample.
   - PRESSED falls 6 cycles after the high sample, with SHORT_PULSE=1 in that cycle.
   - LONG_PULSE and REPEAT_PULSE stay 0.
2. **Bounce rejection.** Toggle BTN_N every 2 cycles for 20 cycles, then hold high → all outputs stay 0. Then hold low with 1-cycle high glitches every 3 cycles → PRESSED never rises.
3. **Long press with repeat.** BTN_N low for 45 cycles.
   - LONG_PULSE 20 cycles after PRESSED rises.
   - REPEAT_PULSE 5, 10 and 15 cycles after LONG_PULSE.
   - On release, PRESSED falls with no SHORT_PULSE.
4. **Release bounce inside a hold.** During HELD, drive BTN_N high for 2 cycles, then low again.
   - PRESSED stays 1.
   - LONG_PULSE is delayed by exactly the cycles spent in DEB_RELEASE.
5. **Reset mid-press.** Assert RST for 1 cycle while in HELD with BTN_N still low.
   - All outputs are 0 the next cycle; no SHORT_PULSE.
   - PRESSED rises again 6 cycles after RST deasserts.
6. **Pulse width.** Over scenarios 1–5, check that every pulse output is exactly 1 cycle wide and that no two event pulses are ever high together.
